// File: rtl/fetch_unit.sv
// Fetch-side datapath: program counter, instruction register and operand register,
// with the memory address mux, a protocol-violation flag and a saturating fetch counter.
module fetch_unit #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter logic [AW-1:0] RST_PC = '0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       fetch,
  input  logic             PC_en,
  input  logic             pc_chg_en,
  input  logic             ad_sel,
  input  logic             rom_ena,
  input  logic             rom_read,
  input  logic [DW-1:0]    rom_data,
  output logic [AW-1:0]    rom_addr,
  output logic [AW-1:0]    addr,
  output logic [AW-1:0]    pc,
  output logic [3:0]       ins,
  output logic [DW-5:0]    reg_idx,
  output logic [DW-1:0]    oper,
  output logic             halted,
  output logic             proto_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [1:0] FETCH_HOLD = 2'b00;
  localparam logic [1:0] FETCH_IR   = 2'b01;
  localparam logic [1:0] FETCH_OPER = 2'b10;

  // Handshake: rom_data is only trusted in a cycle where rom_ena & rom_read (rd_ok)
  // are both high; a load request (fetch 01/10) without rd_ok is a violation.
  logic          rd_ok;
  logic          load_ir;
  logic          load_oper;
  logic          bad_fetch;
  logic [DW-1:0] ir;

  assign rd_ok     = rom_ena & rom_read;
  assign load_ir   = (fetch == FETCH_IR)   & rd_ok;
  assign load_oper = (fetch == FETCH_OPER) & rd_ok;
  assign bad_fetch = (fetch != FETCH_HOLD) & ~load_ir & ~load_oper;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir        <= '0;
      oper      <= '0;
      halted    <= 1'b0;
      proto_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      proto_err <= bad_fetch;
      if (load_ir) begin
        ir     <= rom_data;
        halted <= (rom_data[DW-1:DW-4] == 4'hF);
        if (fetch_cnt != {CNT_W{1'b1}}) begin
          fetch_cnt <= fetch_cnt + 1'b1;
        end
      end
      if (load_oper) begin
        oper <= rom_data;
      end
    end
  end

  // Jump bypass takes the target straight off the ROM bus so a JMP needs no extra cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RST_PC;
    end else if (PC_en && pc_chg_en && load_oper) begin
      pc <= rom_data[AW-1:0];
    end else if (PC_en && pc_chg_en) begin
      pc <= oper[AW-1:0];
    end else if (PC_en) begin
      pc <= pc + 1'b1;
    end
  end

  assign rom_addr = pc;
  assign addr     = ad_sel ? oper[AW-1:0] : pc;
  assign ins      = ir[DW-1:DW-4];
  assign reg_idx  = ir[DW-5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: linear steps with hand-computed expectations
// checked by immediate assertions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fetch;
  logic        PC_en;
  logic        pc_chg_en;
  logic        ad_sel;
  logic        rom_ena;
  logic        rom_read;
  logic [7:0]  rom_data;
  logic [7:0]  rom_addr;
  logic [7:0]  addr;
  logic [7:0]  pc;
  logic [3:0]  ins;
  logic [3:0]  reg_idx;
  logic [7:0]  oper;
  logic        halted;
  logic        proto_err;
  logic [15:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .PC_en     (PC_en),
    .pc_chg_en (pc_chg_en),
    .ad_sel    (ad_sel),
    .rom_ena   (rom_ena),
    .rom_read  (rom_read),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .addr      (addr),
    .pc        (pc),
    .ins       (ins),
    .reg_idx   (reg_idx),
    .oper      (oper),
    .halted    (halted),
    .proto_err (proto_err),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic idle();
    fetch = 2'b00; PC_en = 1'b0; pc_chg_en = 1'b0; ad_sel = 1'b0;
    rom_ena = 1'b0; rom_read = 1'b0; rom_data = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},        32'(pc),        32'h00);
    check({tag, "_rom_addr"},  32'(rom_addr),  32'h00);
    check({tag, "_addr"},      32'(addr),      32'h00);
    check({tag, "_ins"},       32'(ins),       32'h0);
    check({tag, "_reg_idx"},   32'(reg_idx),   32'h0);
    check({tag, "_oper"},      32'(oper),      32'h00);
    check({tag, "_halted"},    32'(halted),    32'h0);
    check({tag, "_proto_err"}, 32'(proto_err), 32'h0);
    check({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'h0);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    step();
    step();
    check_reset_state("rst");

    // First instruction fetch
    rst = 1'b1;
    fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'h61;
    step();
    idle();
    check("f1_ins",       32'(ins),       32'h6);
    check("f1_reg_idx",   32'(reg_idx),   32'h1);
    check("f1_fetch_cnt", 32'(fetch_cnt), 32'd1);
    check("f1_pc",        32'(pc),        32'h00);
    check("f1_proto_err", 32'(proto_err), 32'h0);

    // Park pc at FE via oper, then increment through the wrap
    fetch = 2'b10; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'hFE;
    step();
    idle();
    check("ld_fe_oper", 32'(oper), 32'hFE);
    check("ld_fe_pc",   32'(pc),   32'h00);
    PC_en = 1'b1; pc_chg_en = 1'b1;
    step();
    check("jmp_oper_pc", 32'(pc), 32'hFE);
    pc_chg_en = 1'b0;
    step();
    check("inc1_pc",       32'(pc),       32'hFF);
    check("inc1_rom_addr", 32'(rom_addr), 32'hFF);
    step();
    check("inc2_pc",       32'(pc),       32'h00);
    check("inc2_rom_addr", 32'(rom_addr), 32'h00);
    step();
    check("inc3_pc",       32'(pc),       32'h01);
    check("inc3_rom_addr", 32'(rom_addr), 32'h01);
    idle();

    // pc_chg_en alone is a hold, not an error
    pc_chg_en = 1'b1;
    step();
    idle();
    check("chg_only_pc",    32'(pc),        32'h01);
    check("chg_only_proto", 32'(proto_err), 32'h0);

    // JMP: opcode E, then operand with jump bypass
    fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'hE0;
    step();
    check("jmp_ins", 32'(ins), 32'hE);
    check("jmp_pc0", 32'(pc),  32'h01);
    fetch = 2'b10; PC_en = 1'b1; pc_chg_en = 1'b1; rom_data = 8'h3C;
    step();
    idle();
    check("jmp_pc",        32'(pc),        32'h3C);
    check("jmp_oper",      32'(oper),      32'h3C);
    check("jmp_fetch_cnt", 32'(fetch_cnt), 32'd2);

    // IR load and pc increment at the same edge
    fetch = 2'b01; PC_en = 1'b1; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'h45;
    step();
    idle();
    check("sim_ins",       32'(ins),       32'h4);
    check("sim_reg_idx",   32'(reg_idx),   32'h5);
    check("sim_pc",        32'(pc),        32'h3D);
    check("sim_fetch_cnt", 32'(fetch_cnt), 32'd3);

    // LDA: operand load, then address mux both ways
    fetch = 2'b10; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'h20;
    step();
    idle();
    check("lda_oper", 32'(oper), 32'h20);
    check("lda_pc",   32'(pc),   32'h3D);
    ad_sel = 1'b1;
    #1;
    check("lda_addr_oper", 32'(addr), 32'h20);
    ad_sel = 1'b0;
    #1;
    check("lda_addr_pc", 32'(addr), 32'h3D);

    // Protocol violations: load without read strobe, then illegal fetch code
    fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b0; rom_data = 8'h99;
    step();
    check("viol1_proto", 32'(proto_err), 32'h1);
    check("viol1_ins",   32'(ins),       32'h4);
    fetch = 2'b11; rom_read = 1'b1; rom_data = 8'h77;
    step();
    idle();
    check("viol2_proto",   32'(proto_err), 32'h1);
    check("viol2_ins",     32'(ins),       32'h4);
    check("viol2_reg_idx", 32'(reg_idx),   32'h5);
    check("viol2_oper",    32'(oper),      32'h20);
    check("viol2_cnt",     32'(fetch_cnt), 32'd3);
    step();
    check("viol_clear", 32'(proto_err), 32'h0);

    // HLT decode
    fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1; rom_data = 8'hF0;
    step();
    check("hlt_halted", 32'(halted),    32'h1);
    check("hlt_ins",    32'(ins),       32'hF);
    check("hlt_cnt",    32'(fetch_cnt), 32'd4);

    // Mid-sequence reset overrides a pending load and pc update
    rst = 1'b0;
    fetch = 2'b01; PC_en = 1'b1; rom_data = 8'h12;
    step();
    check_reset_state("mid_rst");
    rst = 1'b1;
    idle();
    step();
    check("post_rst_pc", 32'(pc), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
